// File: rtl/stress_pkg.sv
// ---------------------------------------------------------------------------
// stress_pkg
// Shared definitions for the three-sensor stress scan controller:
//   - state_t      : scan FSM encoding (IDLE / SAMPLE / EVAL)
//   - NUM_CH       : number of scanned sensor channels
//   - CH0..CH2     : channel index constants (also the samp_sel encoding)
//   - DEFAULT_THR  : reset threshold for an 8-bit datapath
//   - default_thr(): mid-scale reset threshold for any data width
// ---------------------------------------------------------------------------
package stress_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_EVAL   = 2'd2
    } state_t;

    localparam int NUM_CH = 3;

    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;

    localparam int DEFAULT_THR = 128;

    // Mid-scale value 2**(w-1) used as the reset threshold.
    function automatic int unsigned default_thr(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/stress_scan_ctrl_window_timer.sv
// ---------------------------------------------------------------------------
// window_timer
// One coincidence-window timer. Reloads to WINDOW on load, otherwise counts
// down by one on each tick and parks at zero. A reload in the same cycle as
// a tick wins. open is high while the count is nonzero.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high; clears the count
//   tick   in   1 kHz decrement strobe
//   load   in   reload strobe (channel hit)
//   open   out  window open (count != 0), decoded from the register
// ---------------------------------------------------------------------------
module window_timer #(
    parameter int WIN_W  = 16,
    parameter int WINDOW = 6000
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic load,
    output logic open
);

    logic [WIN_W-1:0] cnt_q;
    logic [WIN_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = WIN_W'(WINDOW);
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign open = (cnt_q != '0);

endmodule

// File: rtl/stress_scan_ctrl.sv
// ---------------------------------------------------------------------------
// stress_scan_ctrl
// Once per tick, scans sensors 0,1,2 through one shared sampler (req/valid),
// compares each sample with a programmable per-channel threshold and reloads
// that channel's coincidence-window timer on a hit. response is high while
// all three windows are open; alarm is derived from response.
//
// Sampler handshake: samp_req is high (with samp_sel stable) for every cycle
// the FSM is in SAMPLE. The sampler answers with a one-cycle samp_valid
// carrying samp_data; the request drops on the same edge that captures the
// data. samp_valid outside SAMPLE is ignored. If no answer arrives within
// TO_CYC cycles the sample is treated as a miss and samp_err pulses.
//
// Build option: STRESS_ALARM_STICKY_EN
//   defined   : alarm sets on response, clears on alarm_ack only while
//               response is low (set wins over ack).
//   undefined : alarm is response delayed by one register; alarm_ack unused.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   tick                  1 kHz one-cycle strobe
//   enable                scan enable; low aborts a scan in progress
//   cfg_we/addr/wdata     threshold write (addr 3 is a no-op)
//   samp_req/sel          sample request and channel select
//   samp_valid/data       sample return
//   hit[2:0]              per-channel hit flags from the last evaluation
//   response              all three windows open
//   alarm, alarm_ack      alarm output and clear request
//   samp_err              one-cycle pulse on sampler timeout
//   overrun               one-cycle pulse on a tick while a scan is busy
//   dbg_state             current FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module stress_scan_ctrl
    import stress_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int WIN_W  = 16,
    parameter int WINDOW = 6000,
    parameter int TO_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              enable,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              samp_req,
    output logic [1:0]        samp_sel,
    input  logic              samp_valid,
    input  logic [DATA_W-1:0] samp_data,
    output logic [2:0]        hit,
    output logic              response,
    output logic              alarm,
    input  logic              alarm_ack,
    output logic              samp_err,
    output logic              overrun,
    output logic [1:0]        dbg_state
);

    localparam int TO_W = $clog2(TO_CYC + 1);
    // Last value of the wait counter before the timeout fires; the request
    // is therefore held for exactly TO_CYC cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
    localparam logic [DATA_W-1:0] THR_RST = DATA_W'(default_thr(DATA_W));

    state_t             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic [TO_W-1:0]    wait_q, wait_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               got_q, got_d;      // captured sample is real (not a timeout)
    logic [2:0]         hit_q, hit_d;
    logic               samp_err_q, samp_err_d;
    logic               overrun_q, overrun_d;
    logic               alarm_q, alarm_d;
    logic [DATA_W-1:0]  thr_q [NUM_CH];
    logic [NUM_CH-1:0]  load;
    logic [NUM_CH-1:0]  win_open;

    // ---------------- scan FSM: next state ----------------
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        wait_d     = wait_q;
        data_d     = data_q;
        got_d      = got_q;
        hit_d      = hit_q;
        samp_err_d = 1'b0;
        overrun_d  = tick && (state_q != ST_IDLE);
        load       = '0;

        case (state_q)
            ST_IDLE: begin
                if (enable && tick) begin
                    state_d = ST_SAMPLE;
                    ch_d    = CH0;
                    wait_d  = '0;
                end
            end

            ST_SAMPLE: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (samp_valid) begin
                    data_d  = samp_data;
                    got_d   = 1'b1;
                    state_d = ST_EVAL;
                end else if (wait_q == TO_LAST) begin
                    got_d      = 1'b0;
                    samp_err_d = 1'b1;
                    state_d    = ST_EVAL;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end

            ST_EVAL: begin
                if (!enable) begin
                    // Abort leaves hit flags and timers exactly as they were.
                    state_d = ST_IDLE;
                end else begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (int'(ch_q) == i) begin
                            hit_d[i] = got_q && (data_q >= thr_q[i]);
                            load[i]  = got_q && (data_q >= thr_q[i]);
                        end
                    end
                    if (ch_q == CH2) begin
                        state_d = ST_IDLE;
                    end else begin
                        ch_d    = ch_q + 2'd1;
                        wait_d  = '0;
                        state_d = ST_SAMPLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- scan FSM: registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ch_q       <= CH0;
            wait_q     <= '0;
            data_q     <= '0;
            got_q      <= 1'b0;
            hit_q      <= '0;
            samp_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            wait_q     <= wait_d;
            data_q     <= data_d;
            got_q      <= got_d;
            hit_q      <= hit_d;
            samp_err_q <= samp_err_d;
            overrun_q  <= overrun_d;
        end
    end

    // ---------------- threshold registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                thr_q[i] <= THR_RST;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (int'(cfg_addr) == i) begin
                    thr_q[i] <= cfg_wdata;
                end
            end
        end
    end

    // ---------------- coincidence windows ----------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_tmr
        window_timer #(
            .WIN_W  (WIN_W),
            .WINDOW (WINDOW)
        ) u_tmr (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .load  (load[g]),
            .open  (win_open[g])
        );
    end

    assign response = &win_open;

    // ---------------- alarm ----------------
`ifdef STRESS_ALARM_STICKY_EN
    always_comb begin
        alarm_d = alarm_q;
        if (response) begin
            alarm_d = 1'b1;
        end else if (alarm_ack) begin
            alarm_d = 1'b0;
        end
    end
`else
    logic unused_alarm_ack;
    assign unused_alarm_ack = alarm_ack;

    always_comb begin
        alarm_d = response;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    // ---------------- outputs ----------------
    assign samp_req  = (state_q == ST_SAMPLE);
    assign samp_sel  = ch_q;
    assign hit       = hit_q;
    assign alarm     = alarm_q;
    assign samp_err  = samp_err_q;
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: doc/stress_scan_ctrl.md
Name: stress_scan_ctrl

Overview:
- Scheduler/controller for the three-sensor stress coincidence datapath.
- Once per 1 kHz tick it scans sensors 0,1,2 in turn through one shared sampler, using a req/valid handshake.
- Each sample is compared to a per-channel programmable threshold. A hit reloads that channel's coincidence-window timer.
- Asserts response while all three windows are open; raises alarm (optionally sticky) from response.

Parameters:
- DATA_W, 8: sampler data width and threshold width.
- WIN_W, 16: window timer width.
- WINDOW, 6000: timer reload value in ticks (6 s at 1 kHz); must be < 2**WIN_W.
- TO_CYC, 255: clk cycles to wait for samp_valid before declaring timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- tick  in  1  one-clk pulse at 1 kHz, from the shared divider
- enable  in  1  scan enable
- cfg_we  in  1  threshold write strobe
- cfg_addr  in  2  channel 0..2; 3 is ignored
- cfg_wdata  in  DATA_W  threshold value
- samp_req  out  1  sample request to shared sampler
- samp_sel  out  2  channel being sampled
- samp_valid  in  1  sample returned (one-clk pulse)
- samp_data  in  DATA_W  sample value
- hit  out  3  registered per-channel hit flags from the last scan
- response  out  1  all three windows open
- alarm  out  1  alarm output
- alarm_ack  in  1  alarm clear request
- samp_err  out  1  one-clk pulse on sampler timeout
- overrun  out  1  one-clk pulse when a tick arrives while a scan is busy

Behaviour:
- Reset (async, any state) forces:
  - FSM to IDLE; ch=0.
  - samp_req=0, samp_sel=0, hit=0, samp_err=0, overrun=0, alarm=0.
  - All timers 0, so response=0.
  - All thresholds = 2**(DATA_W-1), i.e. 128.
- FSM states: IDLE, SAMPLE, EVAL.
- IDLE:
  - On enable && tick, go to SAMPLE with ch=0.
- SAMPLE:
  - samp_req=1 and samp_sel=ch, held stable until samp_valid.
  - On samp_valid, capture samp_data and go to EVAL. samp_req drops in the same edge.
  - If the wait counter reaches TO_CYC, pulse samp_err, treat the sample as no-hit, and go to EVAL.
- EVAL (1 cycle):
  - hit[ch] <= (data >= thr[ch]); unsigned compare, width DATA_W.
  - If hit, timer[ch] <= WINDOW.
  - If ch==2, go to IDLE; otherwise ch++ and go to SAMPLE.
- Scan latency: 2 cycles per channel plus sampler latency.
- A threshold of 0 always hits. A threshold of 2**DATA_W-1 hits only on full scale.
- Timers:
  - On tick, every nonzero timer decrements by 1; a timer at 0 stays at 0 (no wrap).
  - Reload and decrement in the same cycle: reload wins, timer = WINDOW.
  - Timers run regardless of enable and FSM state.
- response = (t0!=0)&&(t1!=0)&&(t2!=0), decoded from registers only; no combinational path from any input.
- Tick while FSM is not IDLE: the tick is not queued; overrun pulses 1 cycle. It still decrements the timers.
- enable low in SAMPLE or EVAL: abort to IDLE next cycle, samp_req=0 next cycle. hit and timers are untouched.
- samp_valid outside SAMPLE is ignored.
- cfg_we writes thr[cfg_addr] at the next edge. It is legal mid-scan and takes effect at the next EVAL of that channel. cfg_addr=3 is a no-op.
- alarm behaviour is defined under Optional Feature.

Optional Feature:
- Macro: STRESS_ALARM_STICKY_EN
- Defined:
  - alarm sets when response=1.
  - alarm clears only on alarm_ack while response=0.
  - alarm_ack while response=1 is ignored.
  - Simultaneous set and ack: set wins.
- Undefined:
  - alarm is a register that follows response with 1-cycle delay.
  - alarm_ack is unused.

Decomposition:
- Package stress_pkg holds:
  - FSM state encoding (IDLE/SAMPLE/EVAL).
  - NUM_CH=3.
  - Channel index constants CH0..CH2.
  - Default threshold constant.
- Sub-module window_timer (params WIN_W, WINDOW; ports clk, reset, tick, load, open), instanced 3 times.
- FSM, threshold registers and alarm logic stay in stress_scan_ctrl.

Test Plan:
- Reset mid-SAMPLE with timers loaded -> next cycle samp_req=0, response=0, alarm=0, thresholds read back as 128 via hit behaviour.
- Default thresholds, sampler returns 200,200,200 after 3 cycles on one tick -> hit=3'b111, response=1 right after channel 2's EVAL. With no further hits, response falls exactly 6000 ticks later.
- Channel 0 hits at tick 0, channel 1 at tick 3000, channel 2 at tick 6001 -> response never asserts (t0 already expired).
- Sampler never answers channel 1 -> samp_err pulses after 255 cycles, hit[1]=0, scan continues to channel 2 then returns to IDLE.
- Tick asserted during SAMPLE -> overrun pulses 1 cycle, no second scan starts, all timers still decrement by 1.
- With STRESS_ALARM_STICKY_EN: response 1 then 0 -> alarm stays 1. Ack while response=1 is ignored; ack after response=0 gives alarm=0. Without the macro, alarm drops 1 cycle after response.
